// File: rtl/alu_reservation_station.sv
// Purpose: ALU reservation station; buffers issued ops until both operands are known, snoops ALU/LSB broadcasts, dispatches one ready op per cycle.
// Latency: op issued with no pending operand at edge N is dispatched (alu_en=1) after edge N+1; a woken op dispatches the cycle after wakeup.
// Backpressure: rs_full is high when no entry is free (issues are then dropped); rdy=0 freezes all state. Optional macro RS_AGE_SELECT_EN selects oldest-first dispatch.
module alu_reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int RS_IDX_W  = 4,
    parameter int ROB_POS_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 issue,
    input  logic [6:0]           iss_opcode,
    input  logic [2:0]           iss_func3,
    input  logic                 iss_func7,
    input  logic                 iss_has_dep1,
    input  logic [ROB_POS_W-1:0] iss_dep1,
    input  logic [31:0]          iss_val1,
    input  logic                 iss_has_dep2,
    input  logic [ROB_POS_W-1:0] iss_dep2,
    input  logic [31:0]          iss_val2,
    input  logic [31:0]          iss_imm,
    input  logic [31:0]          iss_pc,
    input  logic [ROB_POS_W-1:0] iss_rob_pos,
    output logic                 rs_full,
    input  logic                 alu_result,
    input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
    input  logic [31:0]          alu_result_val,
    input  logic                 lsb_result,
    input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
    input  logic [31:0]          lsb_result_val,
    output logic                 alu_en,
    output logic [6:0]           opcode,
    output logic [2:0]           func3,
    output logic                 func7,
    output logic [31:0]          val1,
    output logic [31:0]          val2,
    output logic [31:0]          imm,
    output logic [31:0]          pc,
    output logic [ROB_POS_W-1:0] rob_pos
);

    typedef struct packed {
        logic [6:0]           opcode;
        logic [2:0]           func3;
        logic                 func7;
        logic                 has_dep1;
        logic [ROB_POS_W-1:0] dep1;
        logic [31:0]          val1;
        logic                 has_dep2;
        logic [ROB_POS_W-1:0] dep2;
        logic [31:0]          val2;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [ROB_POS_W-1:0] rob_pos;
    } entry_t;

    entry_t               ent     [RS_SIZE];
    entry_t               ent_nxt [RS_SIZE];
    entry_t               iss_ent;
    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   busy_nxt;
    logic [RS_SIZE-1:0]   ready;
    logic [RS_IDX_W-1:0]  free_idx;
    logic [RS_IDX_W-1:0]  sel_idx;
    logic                 sel_vld;
    logic                 issue_take;

    // Resolve one operand against both broadcast buses; returns {still_pending, value}.
    function automatic logic [32:0] snoop(input logic has_dep, input logic [ROB_POS_W-1:0] dep,
                                          input logic [31:0] val);
        if (has_dep && alu_result && dep == alu_result_rob_pos)
            snoop = {1'b0, alu_result_val};
        else if (has_dep && lsb_result && dep == lsb_result_rob_pos)
            snoop = {1'b0, lsb_result_val};
        else
            snoop = {has_dep, val};
    endfunction

    // Lowest free slot, full flag and per-entry readiness from registered state.
    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = RS_IDX_W'(i);
        end
        rs_full    = &busy;
        issue_take = issue && !rs_full;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy[i] && !ent[i].has_dep1 && !ent[i].has_dep2;
        end
    end

`ifdef RS_AGE_SELECT_EN
    logic [RS_IDX_W-1:0] age [RS_SIZE];
    logic [RS_IDX_W-1:0] best_age;

    // Oldest ready entry wins; strict compare keeps the lowest index on a tie.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        best_age = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!sel_vld || age[i] > best_age)) begin
                sel_vld  = 1'b1;
                sel_idx  = RS_IDX_W'(i);
                best_age = age[i];
            end
        end
    end

    // New entry starts at age 0; every other live entry ages by one (saturating).
    always_ff @(posedge clk) begin
        if (rdy && issue_take) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (RS_IDX_W'(i) == free_idx)
                    age[i] <= '0;
                else if (busy[i] && age[i] != '1)
                    age[i] <= age[i] + 1'b1;
            end
        end
    end
`else
    // Lowest-index ready entry wins.
    always_comb begin
        sel_vld = |ready;
        sel_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) sel_idx = RS_IDX_W'(i);
        end
    end
`endif

    // Next entry payload: wakeup on every entry, the issued op (with forwarding) into the free slot.
    always_comb begin
        iss_ent          = '0;
        iss_ent.opcode   = iss_opcode;
        iss_ent.func3    = iss_func3;
        iss_ent.func7    = iss_func7;
        iss_ent.dep1     = iss_dep1;
        iss_ent.dep2     = iss_dep2;
        iss_ent.imm      = iss_imm;
        iss_ent.pc       = iss_pc;
        iss_ent.rob_pos  = iss_rob_pos;
        {iss_ent.has_dep1, iss_ent.val1} = snoop(iss_has_dep1, iss_dep1, iss_val1);
        {iss_ent.has_dep2, iss_ent.val2} = snoop(iss_has_dep2, iss_dep2, iss_val2);
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_nxt[i] = ent[i];
            {ent_nxt[i].has_dep1, ent_nxt[i].val1} = snoop(ent[i].has_dep1, ent[i].dep1, ent[i].val1);
            {ent_nxt[i].has_dep2, ent_nxt[i].val2} = snoop(ent[i].has_dep2, ent[i].dep2, ent[i].val2);
            if (issue_take && free_idx == RS_IDX_W'(i)) ent_nxt[i] = iss_ent;
        end
    end

    // Busy vector update: dispatch frees one slot, issue claims one (never the same slot).
    always_comb begin
        busy_nxt = busy;
        if (sel_vld) busy_nxt[sel_idx] = 1'b0;
        if (issue_take) busy_nxt[free_idx] = 1'b1;
    end

    // Entry payload register; busy gates its meaning so it needs no reset.
    always_ff @(posedge clk) begin
        if (rdy) ent <= ent_nxt;
    end

    // Control state and registered dispatch bundle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy    <= '0;
            alu_en  <= 1'b0;
            opcode  <= '0;
            func3   <= '0;
            func7   <= 1'b0;
            val1    <= '0;
            val2    <= '0;
            imm     <= '0;
            pc      <= '0;
            rob_pos <= '0;
        end else if (rdy) begin
            if (rollback) begin
                busy    <= '0;
                alu_en  <= 1'b0;
                opcode  <= '0;
                func3   <= '0;
                func7   <= 1'b0;
                val1    <= '0;
                val2    <= '0;
                imm     <= '0;
                pc      <= '0;
                rob_pos <= '0;
            end else begin
                busy   <= busy_nxt;
                alu_en <= sel_vld;
                if (sel_vld) begin
                    opcode  <= ent[sel_idx].opcode;
                    func3   <= ent[sel_idx].func3;
                    func7   <= ent[sel_idx].func7;
                    val1    <= ent[sel_idx].val1;
                    val2    <= ent[sel_idx].val2;
                    imm     <= ent[sel_idx].imm;
                    pc      <= ent[sel_idx].pc;
                    rob_pos <= ent[sel_idx].rob_pos;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios with literal expectations plus randomized traffic.
// An array-based model of the station predicts rs_full and the dispatch bundle every cycle.
// Default build only (lowest-index dispatch policy).
module tb_alu_reservation_station;

    logic        clk, rst, rdy, rollback, issue;
    logic [6:0]  iss_opcode;
    logic [2:0]  iss_func3;
    logic        iss_func7, iss_has_dep1, iss_has_dep2;
    logic [3:0]  iss_dep1, iss_dep2, iss_rob_pos;
    logic [31:0] iss_val1, iss_val2, iss_imm, iss_pc;
    logic        rs_full;
    logic        alu_result, lsb_result;
    logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
    logic [31:0] alu_result_val, lsb_result_val;
    logic        alu_en;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic [31:0] val1, val2, imm, pc;
    logic [3:0]  rob_pos;

    int checks = 0;
    int errors = 0;

    alu_reservation_station #(.RS_SIZE(16), .RS_IDX_W(4), .ROB_POS_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .issue(issue),
        .iss_opcode(iss_opcode), .iss_func3(iss_func3), .iss_func7(iss_func7),
        .iss_has_dep1(iss_has_dep1), .iss_dep1(iss_dep1), .iss_val1(iss_val1),
        .iss_has_dep2(iss_has_dep2), .iss_dep2(iss_dep2), .iss_val2(iss_val2),
        .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_rob_pos(iss_rob_pos), .rs_full(rs_full),
        .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
        .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val),
        .alu_en(alu_en), .opcode(opcode), .func3(func3), .func7(func7), .val1(val1), .val2(val2),
        .imm(imm), .pc(pc), .rob_pos(rob_pos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy [16];
    bit          m_hd1 [16], m_hd2 [16];
    logic [3:0]  m_d1 [16], m_d2 [16], m_rob [16];
    logic [31:0] m_v1 [16], m_v2 [16], m_imm [16], m_pc [16];
    logic [6:0]  m_op [16];
    logic [2:0]  m_f3 [16];
    logic        m_f7 [16];
    bit          model_ok = 0;
    logic        e_en;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic        e_f7;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    logic [3:0]  e_rob;

    // Operand value after looking at this cycle's broadcasts: {pending, value}.
    function automatic logic [32:0] look(input bit hd, input logic [3:0] d, input logic [31:0] v);
        if (hd && alu_result && d == alu_result_rob_pos) return {1'b0, alu_result_val};
        if (hd && lsb_result && d == lsb_result_rob_pos) return {1'b0, lsb_result_val};
        return {hd, v};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_busy[i] = 0;
        e_en = 0; e_op = 0; e_f3 = 0; e_f7 = 0;
        e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0;
    endtask

    always @(posedge clk) begin
        int fi, si;
        logic [32:0] r;
        if (!rst) begin
            model_clear();
            model_ok = 1;
        end else if (rdy && model_ok) begin
            if (rollback) begin
                model_clear();
            end else begin
                fi = -1; si = -1;
                for (int i = 0; i < 16; i++) begin
                    if (!m_busy[i] && fi < 0) fi = i;
                    if (m_busy[i] && !m_hd1[i] && !m_hd2[i] && si < 0) si = i;
                end
                e_en = (si >= 0);
                if (si >= 0) begin
                    e_op = m_op[si]; e_f3 = m_f3[si]; e_f7 = m_f7[si];
                    e_v1 = m_v1[si]; e_v2 = m_v2[si]; e_imm = m_imm[si];
                    e_pc = m_pc[si]; e_rob = m_rob[si];
                    m_busy[si] = 0;
                end
                for (int i = 0; i < 16; i++) begin
                    r = look(m_hd1[i], m_d1[i], m_v1[i]); m_hd1[i] = r[32]; m_v1[i] = r[31:0];
                    r = look(m_hd2[i], m_d2[i], m_v2[i]); m_hd2[i] = r[32]; m_v2[i] = r[31:0];
                end
                if (issue && fi >= 0) begin
                    m_busy[fi] = 1;
                    m_op[fi] = iss_opcode; m_f3[fi] = iss_func3; m_f7[fi] = iss_func7;
                    m_d1[fi] = iss_dep1; m_d2[fi] = iss_dep2;
                    m_imm[fi] = iss_imm; m_pc[fi] = iss_pc; m_rob[fi] = iss_rob_pos;
                    r = look(iss_has_dep1, iss_dep1, iss_val1); m_hd1[fi] = r[32]; m_v1[fi] = r[31:0];
                    r = look(iss_has_dep2, iss_dep2, iss_val2); m_hd2[fi] = r[32]; m_v2[fi] = r[31:0];
                end
            end
        end
    end

    // Compare DUT against the model mid-cycle, every cycle.
    always @(negedge clk) begin
        bit full;
        if (model_ok) begin
            full = 1;
            for (int i = 0; i < 16; i++) if (!m_busy[i]) full = 0;
            chk("m_rs_full", 32'(rs_full), 32'(full));
            chk("m_alu_en", 32'(alu_en), 32'(e_en));
            chk("m_opcode", 32'(opcode), 32'(e_op));
            chk("m_func3", 32'(func3), 32'(e_f3));
            chk("m_func7", 32'(func7), 32'(e_f7));
            chk("m_val1", val1, e_v1);
            chk("m_val2", val2, e_v2);
            chk("m_imm", imm, e_imm);
            chk("m_pc", pc, e_pc);
            chk("m_rob_pos", 32'(rob_pos), 32'(e_rob));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        issue = 0; rollback = 0; alu_result = 0; lsb_result = 0;
        iss_has_dep1 = 0; iss_has_dep2 = 0;
    endtask

    task automatic iss(input logic [6:0] op, input logic hd1, input logic [3:0] d1, input logic [31:0] v1,
                       input logic hd2, input logic [3:0] d2, input logic [31:0] v2,
                       input logic [31:0] im, input logic [3:0] rob);
        issue = 1; iss_opcode = op; iss_func3 = 3'd0; iss_func7 = 1'b0;
        iss_has_dep1 = hd1; iss_dep1 = d1; iss_val1 = v1;
        iss_has_dep2 = hd2; iss_dep2 = d2; iss_val2 = v2;
        iss_imm = im; iss_pc = 32'h1000 + 32'(rob) * 4; iss_rob_pos = rob;
    endtask

    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] ADD  = 7'b0110011;

    initial begin
        rst = 0; rdy = 1; clr();
        iss_opcode = 0; iss_func3 = 0; iss_func7 = 0; iss_dep1 = 0; iss_dep2 = 0;
        iss_val1 = 0; iss_val2 = 0; iss_imm = 0; iss_pc = 0; iss_rob_pos = 0;
        alu_result_rob_pos = 0; alu_result_val = 0; lsb_result_rob_pos = 0; lsb_result_val = 0;

        // Reset hold with an issue request present.
        iss(ADDI, 0, 0, 32'd1, 0, 0, 0, 32'd1, 4'd1);
        cyc(); cyc();
        chk("rst_alu_en", 32'(alu_en), 0);
        chk("rst_rs_full", 32'(rs_full), 0);
        chk("rst_val1", val1, 0);
        chk("rst_opcode", 32'(opcode), 0);
        chk("rst_rob_pos", 32'(rob_pos), 0);
        rst = 1; clr(); cyc();

        // No-dep issue: dispatch one cycle after being written.
        iss(ADDI, 0, 0, 32'd5, 0, 0, 0, 32'd3, 4'd2);
        cyc(); clr();
        chk("nodep_en_n", 32'(alu_en), 0);
        cyc();
        chk("nodep_en", 32'(alu_en), 1);
        chk("nodep_val1", val1, 32'd5);
        chk("nodep_imm", imm, 32'd3);
        chk("nodep_rob", 32'(rob_pos), 32'd2);
        cyc();
        chk("nodep_en_off", 32'(alu_en), 0);

        // Wakeup via ALU bus, then via LSB bus.
        for (int bus = 0; bus < 2; bus++) begin
            iss(ADD, 1, 4'd7, 32'hDEAD, 0, 0, 32'd1, 0, 4'd4);
            cyc(); clr(); cyc();
            if (bus == 0) begin
                alu_result = 1; alu_result_rob_pos = 4'd7; alu_result_val = 32'h10;
            end else begin
                lsb_result = 1; lsb_result_rob_pos = 4'd7; lsb_result_val = 32'h10;
            end
            cyc(); clr();
            chk("wake_en_n", 32'(alu_en), 0);
            cyc();
            chk("wake_en", 32'(alu_en), 1);
            chk("wake_val1", val1, 32'h10);
            chk("wake_val2", val2, 32'd1);
            cyc();
        end

        // Issue-time forwarding from the LSB bus.
        iss(ADD, 0, 0, 32'd8, 1, 4'd3, 32'hBAD, 0, 4'd5);
        lsb_result = 1; lsb_result_rob_pos = 4'd3; lsb_result_val = 32'hABCD;
        cyc(); clr(); cyc();
        chk("fwd_en", 32'(alu_en), 1);
        chk("fwd_val2", val2, 32'hABCD);
        cyc();

        // Fill all 16 entries, then a dropped 17th issue, then drain.
        for (int i = 0; i < 16; i++) begin
            iss(ADD, 1, 4'd9, 0, 0, 0, 32'(i), 32'(i), 4'(i));
            cyc();
        end
        chk("full_set", 32'(rs_full), 1);
        iss(ADD, 0, 0, 32'h77, 0, 0, 0, 32'hEEEE, 4'hE);
        cyc(); clr();
        chk("full_hold", 32'(rs_full), 1);
        chk("full_no_en", 32'(alu_en), 0);
        alu_result = 1; alu_result_rob_pos = 4'd9; alu_result_val = 32'h99;
        cyc(); clr();
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("drain_en", 32'(alu_en), 1);
            chk("drain_rob", 32'(rob_pos), 32'(i));
            chk("drain_val1", val1, 32'h99);
            if (i == 0) chk("drain_full_drop", 32'(rs_full), 0);
        end
        cyc();
        chk("drain_done", 32'(alu_en), 0);

        // Rollback with 5 waiting entries.
        for (int i = 0; i < 5; i++) begin
            iss(ADD, 1, 4'd12, 0, 0, 0, 0, 0, 4'(i + 1));
            cyc();
        end
        clr(); rollback = 1;
        cyc(); clr();
        chk("rb_full", 32'(rs_full), 0);
        chk("rb_en", 32'(alu_en), 0);
        chk("rb_rob", 32'(rob_pos), 0);
        chk("rb_val1", val1, 0);
        alu_result = 1; alu_result_rob_pos = 4'd12; alu_result_val = 32'h5;
        cyc(); clr();
        cyc(); chk("rb_quiet1", 32'(alu_en), 0);
        cyc(); chk("rb_quiet2", 32'(alu_en), 0);

        // rdy=0 freezes a live dispatch and the next ready entry.
        iss(ADDI, 0, 0, 32'hA1, 0, 0, 0, 0, 4'd6);
        cyc();
        iss(ADDI, 0, 0, 32'hB2, 0, 0, 0, 0, 4'd7);
        cyc(); clr();
        chk("rdy_first_en", 32'(alu_en), 1);
        chk("rdy_first_v", val1, 32'hA1);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rdy_hold_en", 32'(alu_en), 1);
            chk("rdy_hold_v", val1, 32'hA1);
        end
        rdy = 1;
        cyc();
        chk("rdy_resume_v", val1, 32'hB2);
        chk("rdy_resume_rob", 32'(rob_pos), 32'd7);
        cyc();
        chk("rdy_idle", 32'(alu_en), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 499) != 0);
            rdy = ($urandom_range(0, 7) != 0);
            rollback = ($urandom_range(0, 63) == 0);
            issue = $urandom_range(0, 2) != 0;
            iss_opcode = 7'($urandom); iss_func3 = 3'($urandom); iss_func7 = 1'($urandom);
            iss_has_dep1 = 1'($urandom); iss_dep1 = 4'($urandom); iss_val1 = $urandom;
            iss_has_dep2 = 1'($urandom); iss_dep2 = 4'($urandom); iss_val2 = $urandom;
            iss_imm = $urandom; iss_pc = $urandom; iss_rob_pos = 4'($urandom);
            alu_result = ($urandom_range(0, 2) == 0);
            alu_result_rob_pos = 4'($urandom); alu_result_val = $urandom;
            lsb_result = ($urandom_range(0, 2) == 0);
            lsb_result_rob_pos = 4'($urandom); lsb_result_val = $urandom;
            if (alu_result && lsb_result && lsb_result_rob_pos == alu_result_rob_pos)
                lsb_result_rob_pos = lsb_result_rob_pos + 4'd1;
            cyc();
        end
        rst = 1; rdy = 1; clr();
        for (int i = 0; i < 20; i++) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station directly upstream of the ALU: buffers arithmetic/branch/jump/LUI/AUIPC ops issued by the decoder until both source operands are available.
- Snoops the ALU and LSB result broadcast buses to wake waiting operands.
- Dispatches at most one ready entry per cycle to the ALU as a registered operand bundle.
- Flushes completely on rollback.

Parameters:
- RS_SIZE, 16, number of entries; power of two.
- RS_IDX_W, 4, log2(RS_SIZE).
- ROB_POS_W, 4, ROB tag width (matches ROB_POS_WID).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset; rst==0 at a rising edge resets.
- rdy  in  1  global ready; when 0, all state and outputs hold.
- rollback  in  1  misprediction flush.
- issue  in  1  decoder issues one op this cycle.
- iss_opcode  in  7  opcode.
- iss_func3  in  3  funct3.
- iss_func7  in  1  instruction bit 30.
- iss_has_dep1  in  1  rs1 pending.
- iss_dep1  in  ROB_POS_W  ROB tag producing rs1.
- iss_val1  in  32  rs1 value when not pending.
- iss_has_dep2  in  1  rs2 pending.
- iss_dep2  in  ROB_POS_W  ROB tag producing rs2.
- iss_val2  in  32  rs2 value when not pending.
- iss_imm  in  32  sign-extended immediate.
- iss_pc  in  32  instruction PC.
- iss_rob_pos  in  ROB_POS_W  destination ROB tag.
- rs_full  out  1  no free entry (combinational from current busy vector).
- alu_result  in  1  ALU broadcast valid.
- alu_result_rob_pos  in  ROB_POS_W  ALU broadcast tag.
- alu_result_val  in  32  ALU broadcast value.
- lsb_result  in  1  LSB broadcast valid.
- lsb_result_rob_pos  in  ROB_POS_W  LSB broadcast tag.
- lsb_result_val  in  32  LSB broadcast value.
- alu_en  out  1  dispatch valid, one-cycle pulse per op.
- opcode  out  7  dispatched opcode.
- func3  out  3  dispatched funct3.
- func7  out  1  dispatched bit 30.
- val1  out  32  dispatched rs1 value.
- val2  out  32  dispatched rs2 value.
- imm  out  32  dispatched immediate.
- pc  out  32  dispatched PC.
- rob_pos  out  ROB_POS_W  dispatched ROB tag.

Behaviour:
- Entry state: busy, opcode, func3, func7, has_dep1/2, dep1/2, val1/2, imm, pc, rob_pos.
- Reset (rst==0) or rollback==1 (reset has priority): all busy=0; alu_en=0; opcode, func3, func7, val1, val2, imm, pc, rob_pos all 0.
- rdy==0: nothing changes, including alu_en. An issue or broadcast presented while rdy==0 is lost; upstream holds.
- Issue:
  - When issue==1 and a free entry exists, write the lowest-index free entry; busy=1 at the next edge.
  - issue while rs_full==1 is ignored; protocol violation.
  - rs_full reflects the busy vector before this cycle's issue/dispatch. A slot freed by dispatch this cycle is usable from the next cycle.
- Issue-time forwarding: if iss_has_depN==1 and a valid broadcast this cycle carries tag iss_depN, store has_depN=0 with the broadcast value.
- Wakeup: every busy entry with has_depN==1 and depN matching a valid ALU or LSB tag clears has_depN and captures that value at the edge. Both buses are checked independently for both operands.
- Ready condition: busy && !has_dep1 && !has_dep2, evaluated on registered entry state. Earliest dispatch is the cycle after the entry is written or woken.
- Dispatch:
  - Each rdy cycle: if any entry is ready, select one (policy below), drive the output registers from it, set alu_en=1, and clear its busy. Otherwise alu_en=0.
  - Latency: issue with no deps at edge N, alu_en=1 after edge N+1.
- Simultaneous issue + dispatch in one cycle: both occur; they never target the same entry, since issue takes a free entry and dispatch a busy one.
- Tag uniqueness is upstream's guarantee; no duplicate-tag checking.
- Output registers hold their last values while alu_en=0.

Optional Feature:
- Macro: RS_AGE_SELECT_EN.
- Defined: each entry carries an RS_IDX_W-bit age counter. Issue sets age 0 and increments the ages of other busy entries. Dispatch picks the ready entry with the largest age (oldest first); on a tie, lowest index wins.
- Undefined: dispatch picks the lowest-index ready entry; no age storage.

Test Plan:
- Reset hold: rst=0 for 2 cycles with issue=1 -> alu_en=0, rs_full=0, all outputs 0.
- No-dep issue: ADDI, val1=5, imm=3, rob_pos=2, issued at edge N -> alu_en=1 after edge N+1, val1=5, imm=3, rob_pos=2; alu_en=0 the following cycle.
- Wakeup:
  - Issue with has_dep1=1, dep1=7.
  - Two cycles later, alu_result=1, tag=7, val=0x10 -> next cycle entry ready; dispatch with val1=0x10.
  - Same scenario via the LSB bus -> identical result.
- Issue-time forward: issue dep2=3 in the same cycle as lsb_result tag=3, val=0xABCD -> dispatch next cycle with val2=0xABCD.
- Full: issue 16 ops all depending on tag 9 -> rs_full=1; a 17th issue is ignored. Broadcast tag 9 -> 16 consecutive alu_en pulses; rs_full drops the cycle after the first dispatch.
- Rollback and rdy:
  - rollback=1 with 5 busy entries -> next cycle all free, alu_en=0, no later dispatches.
  - rdy=0 for 3 cycles with a ready entry -> alu_en and outputs frozen until rdy=1.
